// File: rtl/video_sync_gen.sv
// 15 kHz raster timing generator: free-running h/v counters, registered
// syncs, blanked 3:3:3 colour, display enable and a frame interrupt.
//
// Ports:
//   clkvideo          video clock (14 MHz)
//   reset             synchronous, active-high
//   ri, gi, bi        pixel colour for the current hcnt/vcnt
//   ro, go, bo        registered colour, forced to 0 outside the active area
//   hsync_n           horizontal sync, active low
//   vsync_n           vertical sync, active low
//   csync_n           composite sync, active low
//   de                registered display enable
//   int_n             frame interrupt, active low, INT_LEN clocks wide
//   hcnt, vcnt        raw raster counters
//
// Build option: define VIDEO_SYNC_SERRATION_EN to get serrated csync_n
// (inverted hsync pulses during vsync lines); otherwise csync_n = ~(hs|vs).

module video_sync_gen #(
    parameter int unsigned H_TOTAL      = 896,
    parameter int unsigned H_ACTIVE     = 704,
    parameter int unsigned H_SYNC_START = 752,
    parameter int unsigned H_SYNC_LEN   = 64,
    parameter int unsigned V_TOTAL      = 320,
    parameter int unsigned V_ACTIVE     = 288,
    parameter int unsigned V_SYNC_START = 300,
    parameter int unsigned V_SYNC_LEN   = 4,
    parameter int unsigned INT_H        = 0,
    parameter int unsigned INT_V        = 300,
    parameter int unsigned INT_LEN      = 128
) (
    input  logic       clkvideo,
    input  logic       reset,
    input  logic [2:0] ri,
    input  logic [2:0] gi,
    input  logic [2:0] bi,
    output logic [2:0] ro,
    output logic [2:0] go,
    output logic [2:0] bo,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       csync_n,
    output logic       de,
    output logic       int_n,
    output logic [9:0] hcnt,
    output logic [8:0] vcnt
);

    // Window bounds are one bit wider than the counters so that an end
    // equal to 1024 / 512 compares correctly without wrapping.
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [8:0]  V_LAST   = 9'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT_E  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG   = 11'(H_SYNC_START);
    localparam logic [10:0] HS_END   = 11'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [9:0]  V_ACT_E  = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_BEG   = 10'(V_SYNC_START);
    localparam logic [9:0]  VS_END   = 10'(V_SYNC_START + V_SYNC_LEN);
    localparam logic [9:0]  INT_HPOS = 10'(INT_H);
    localparam logic [8:0]  INT_VPOS = 9'(INT_V);
    localparam logic [9:0]  INT_LOAD = 10'(INT_LEN - 1);

    logic [10:0] h_w;
    logic [9:0]  v_w;
    logic        hs;
    logic        vs;
    logic        de_c;
    logic        int_hit;
    logic [9:0]  int_cnt;

    assign h_w     = {1'b0, hcnt};
    assign v_w     = {1'b0, vcnt};
    assign hs      = (h_w >= HS_BEG) && (h_w < HS_END);
    assign vs      = (v_w >= VS_BEG) && (v_w < VS_END);
    assign de_c    = (h_w < H_ACT_E) && (v_w < V_ACT_E);
    assign int_hit = (hcnt == INT_HPOS) && (vcnt == INT_VPOS);

    always_ff @(posedge clkvideo) begin
        if (reset) begin
            hcnt    <= '0;
            vcnt    <= '0;
            hsync_n <= 1'b1;
            vsync_n <= 1'b1;
            csync_n <= 1'b1;
            de      <= 1'b0;
            ro      <= '0;
            go      <= '0;
            bo      <= '0;
            int_n   <= 1'b1;
            int_cnt <= '0;
        end else begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? 9'd0 : vcnt + 9'd1;
            end else begin
                hcnt <= hcnt + 10'd1;
            end

            hsync_n <= ~hs;
            vsync_n <= ~vs;
`ifdef VIDEO_SYNC_SERRATION_EN
            csync_n <= vs ? hs : ~hs;
`else
            csync_n <= ~(hs | vs);
`endif
            de <= de_c;
            ro <= de_c ? ri : 3'd0;
            go <= de_c ? gi : 3'd0;
            bo <= de_c ? bi : 3'd0;

            // int_n low doubles as the busy flag, so a hit while the
            // pulse is running is simply ignored.
            if (!int_n) begin
                if (int_cnt == 10'd0) begin
                    int_n <= 1'b1;
                end else begin
                    int_cnt <= int_cnt - 10'd1;
                end
            end else if (int_hit) begin
                int_n   <= 1'b0;
                int_cnt <= INT_LOAD;
            end
        end
    end

endmodule

// File: tb/tb_video_sync_gen.sv
// Testbench for video_sync_gen using a scaled-down raster so that several
// frames, a mid-interrupt reset and the restart fit in a short run.

module tb_video_sync_gen;

    localparam int HT    = 40;
    localparam int HA    = 24;
    localparam int HSS   = 28;
    localparam int HSL   = 6;
    localparam int VT    = 20;
    localparam int VA    = 12;
    localparam int VSS   = 14;
    localparam int VSL   = 3;
    localparam int IH    = 5;
    localparam int IV    = 14;
    localparam int IL    = 50;
    localparam int FRAME = HT * VT;
    localparam int TRIG  = IV * HT + IH;

    logic       clkvideo = 1'b0;
    logic       reset    = 1'b1;
    logic [2:0] ri = '0, gi = '0, bi = '0;
    logic [2:0] ro, go, bo;
    logic       hsync_n, vsync_n, csync_n, de, int_n;
    logic [9:0] hcnt;
    logic [8:0] vcnt;

    int n_cmp = 0;
    int n_bad = 0;
    int k     = 0;
    int int_low = 0;
    int hs_low  = 0;
    int vs_low  = 0;

    video_sync_gen #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL),
        .INT_H(IH), .INT_V(IV), .INT_LEN(IL)
    ) dut (
        .clkvideo(clkvideo), .reset(reset),
        .ri(ri), .gi(gi), .bi(bi),
        .ro(ro), .go(go), .bo(bo),
        .hsync_n(hsync_n), .vsync_n(vsync_n), .csync_n(csync_n),
        .de(de), .int_n(int_n), .hcnt(hcnt), .vcnt(vcnt)
    );

    always #5 clkvideo = ~clkvideo;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // Reference: after k edges since reset the raster position is k, and
    // every registered output describes position k-1.
    task automatic check(input logic [8:0] rgb);
        int p, h, v, d;
        bit hs, vs, dc, il, cs;
        if (k == 0) begin
            chk("rst_hcnt", 32'(hcnt), 0);
            chk("rst_vcnt", 32'(vcnt), 0);
            chk("rst_syncs", {29'd0, hsync_n, vsync_n, csync_n}, 7);
            chk("rst_de", 32'(de), 0);
            chk("rst_int", 32'(int_n), 1);
            chk("rst_rgb", 32'({ro, go, bo}), 0);
            return;
        end
        p  = k - 1;
        h  = p % HT;
        v  = (p / HT) % VT;
        hs = (h >= HSS) && (h < HSS + HSL);
        vs = (v >= VSS) && (v < VSS + VSL);
        dc = (h < HA) && (v < VA);
        d  = p - TRIG;
        il = (d >= 0) && ((d % FRAME) < IL);
`ifdef VIDEO_SYNC_SERRATION_EN
        cs = vs ? hs : !hs;
`else
        cs = !(hs || vs);
`endif
        chk("hcnt", 32'(hcnt), 32'(k % HT));
        chk("vcnt", 32'(vcnt), 32'((k / HT) % VT));
        chk("hsync_n", 32'(hsync_n), 32'(!hs));
        chk("vsync_n", 32'(vsync_n), 32'(!vs));
        chk("csync_n", 32'(csync_n), 32'(cs));
        chk("de", 32'(de), 32'(dc));
        chk("rgb", 32'({ro, go, bo}), dc ? 32'(rgb) : 0);
        chk("int_n", 32'(int_n), 32'(!il));
        if (!int_n) int_low++;
        if (!hsync_n) hs_low++;
        if (!vsync_n) vs_low++;
    endtask

    task automatic tick(input bit rst);
        logic [8:0] rgb;
        reset = rst;
        rgb   = {ri, gi, bi};
        @(posedge clkvideo);
        #1;
        if (rst) k = 0;
        else k++;
        check(rgb);
        {ri, gi, bi} = 9'($urandom_range(0, 511));
    endtask

    initial begin
        if (!(HSS + HSL <= HT && HT <= 1024 && VSS + VSL <= VT && VT <= 512 &&
              HA <= HSS && VA <= VSS && HSL >= 1 && IL >= 1 && IL <= 1023)) begin
            $display("FAIL params illegal raster parameters");
            $fatal(1, "illegal parameters");
        end

        repeat (3) tick(1'b1);

        int_low = 0;
        hs_low  = 0;
        vs_low  = 0;
        repeat (2 * FRAME) tick(1'b0);
        chk("int_low_2frames", int_low, 2 * IL);
        chk("hs_low_2frames", hs_low, 2 * VT * HSL);
        chk("vs_low_2frames", vs_low, 2 * VSL * HT);

        while (k < 2 * FRAME + TRIG + 11) tick(1'b0);
        chk("int_active_pre_reset", 32'(int_n), 0);

        tick(1'b1);
        chk("int_aborted", 32'(int_n), 1);

        int_low = 0;
        repeat (FRAME + 25) tick(1'b0);
        chk("int_low_after_reset", int_low, IL);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
